id_operand_stage: RTL and testbench

Registered, parametrised decode-to-execute operand stage for the superscalar core. Captures up to `LANES` decoded instructions per cycle and resolves each lane's two source operands from the register file or one of `NUM_BYP` bypass buses (AU, MUL, LSU, WB results). It presents the result as a one-cycle-latency valid/ready packet to the issue logic, with an optional skid buffer and a flush for taken jumps.

---
 rtl/id_pkg.sv | 24 ++
 rtl/id_operand_mux.sv | 27 ++
 rtl/id_operand_stage.sv | 129 ++++++++++++
 tb/tb_id_operand_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types and constants for the decode-to-execute operand stage.
package id_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Operand select encodings driven by the hazard unit
    localparam int SEL_RF   = 0;
    localparam int SEL_AU1  = 1;
    localparam int SEL_AU2  = 2;
    localparam int SEL_MUL1 = 3;
    localparam int SEL_MUL2 = 4;
    localparam int SEL_LSU  = 5;
    localparam int SEL_WB1  = 6;
    localparam int SEL_WB2  = 7;

    typedef struct packed {
        logic [31:0]             instr;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] op1;
        logic [XLEN_DEFAULT-1:0] op2;
        logic                    valid;
    } lane_pkt_t;

endpackage

// File: rtl/id_operand_mux.sv
// Single-operand select: register file, one of NUM_BYP bypass buses, or zero.
module id_operand_mux
    import id_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_BYP = 7,
    localparam int SEL_W  = $clog2(NUM_BYP + 1)
) (
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_BYP*XLEN-1:0] byp_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [XLEN-1:0]         op
);

    // Encodings beyond NUM_BYP fall through to zero
    always_comb begin
        op = '0;
        if (sel == SEL_W'(SEL_RF)) begin
            op = rf_data;
        end else begin
            for (int k = 0; k < NUM_BYP; k++) begin
                op = (sel == SEL_W'(k + 1)) ? byp_data[XLEN*k +: XLEN] : op;
            end
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Registered operand stage: resolves source operands and hands a valid/ready packet to issue.
// Define ID_OPERAND_SKID_EN to add a one-entry skid buffer behind the output register.
module id_operand_stage
    import id_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int LANES       = 2,
    parameter int NUM_BYP     = 7,
    parameter int STALL_CNT_W = 16,
    localparam int SEL_W      = $clog2(NUM_BYP + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_valid,
    input  logic [LANES*32-1:0]      in_instr,
    input  logic [LANES*XLEN-1:0]    in_pc,
    input  logic [LANES*XLEN-1:0]    rf_rs1_data,
    input  logic [LANES*XLEN-1:0]    rf_rs2_data,
    input  logic [NUM_BYP*XLEN-1:0]  byp_data,
    input  logic [LANES*SEL_W-1:0]   sel_rs1,
    input  logic [LANES*SEL_W-1:0]   sel_rs2,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_valid,
    output logic [LANES*32-1:0]      out_instr,
    output logic [LANES*XLEN-1:0]    out_pc,
    output logic [LANES*XLEN-1:0]    out_op1,
    output logic [LANES*XLEN-1:0]    out_op2,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    localparam int PKT_W = LANES * (1 + 32 + 3 * XLEN);

    logic [LANES*XLEN-1:0]  op1_s;
    logic [LANES*XLEN-1:0]  op2_s;
    logic [PKT_W-1:0]       in_pkt_s;
    logic [PKT_W-1:0]       out_pkt_r;
    logic                   out_valid_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   accept_s;
    logic                   drain_s;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        id_operand_mux #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_rs1_mux (
            .rf_data  (rf_rs1_data[XLEN*i +: XLEN]),
            .byp_data (byp_data),
            .sel      (sel_rs1[SEL_W*i +: SEL_W]),
            .op       (op1_s[XLEN*i +: XLEN])
        );
        id_operand_mux #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_rs2_mux (
            .rf_data  (rf_rs2_data[XLEN*i +: XLEN]),
            .byp_data (byp_data),
            .sel      (sel_rs2[SEL_W*i +: SEL_W]),
            .op       (op2_s[XLEN*i +: XLEN])
        );
    end

    assign in_pkt_s = {in_lane_valid, in_instr, in_pc, op1_s, op2_s};
    assign accept_s = in_valid && in_ready && !flush;
    assign drain_s  = !out_valid_r || out_ready;

`ifdef ID_OPERAND_SKID_EN
    logic             skid_full_r;
    logic [PKT_W-1:0] skid_pkt_r;

    assign in_ready = !skid_full_r;

    // Output register fed by the skid entry first, then by fresh input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_pkt_r   <= '0;
            skid_full_r <= 1'b0;
            skid_pkt_r  <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            skid_full_r <= 1'b0;
        end else if (drain_s) begin
            if (skid_full_r) begin
                out_valid_r <= 1'b1;
                out_pkt_r   <= skid_pkt_r;
                skid_full_r <= 1'b0;
            end else begin
                out_valid_r <= accept_s;
                if (accept_s) begin
                    out_pkt_r <= in_pkt_s;
                end
            end
        end else if (accept_s) begin
            skid_full_r <= 1'b1;
            skid_pkt_r  <= in_pkt_s;
        end
    end
`else
    assign in_ready = out_ready || !out_valid_r;

    // Single output register; input is only taken when it can be loaded directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_pkt_r   <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (drain_s) begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_pkt_r <= in_pkt_s;
            end
        end
    end
`endif

    // Saturating count of cycles the issue logic held off a valid packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (out_valid_r && !out_ready && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end
    end

    assign out_valid = out_valid_r;
    assign stall_cnt = stall_cnt_r;
    assign {out_lane_valid, out_instr, out_pc, out_op1, out_op2} = out_pkt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage with an output scoreboard; a second instance
// (NUM_BYP=6, STALL_CNT_W=4) covers out-of-range selects and counter saturation.
module tb_id_operand_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   in_lane_valid;
    logic [63:0]  in_instr, in_pc, rf_rs1_data, rf_rs2_data;
    logic [223:0] byp_data;
    logic [5:0]   sel_rs1, sel_rs2;
    logic         flush, out_ready;
    logic [31:0]  bus [7];

    logic         in_ready, out_valid;
    logic [1:0]   out_lane_valid;
    logic [63:0]  out_instr, out_pc, out_op1, out_op2;
    logic [15:0]  stall_cnt;

    logic         s_in_ready, s_out_valid;
    logic [1:0]   s_out_lane_valid;
    logic [63:0]  s_out_instr, s_out_pc, s_out_op1, s_out_op2;
    logic [3:0]   s_stall_cnt;

    typedef struct {
        logic [1:0]  lv;
        logic [63:0] instr, pc, op1, op2;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    logic exp_rdy;

    always #5 clk = ~clk;

    assign byp_data = {bus[6], bus[5], bus[4], bus[3], bus[2], bus[1], bus[0]};

    id_operand_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .byp_data(byp_data),
        .sel_rs1(sel_rs1), .sel_rs2(sel_rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_instr(out_instr), .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .stall_cnt(stall_cnt)
    );

    id_operand_stage #(.NUM_BYP(6), .STALL_CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .byp_data(byp_data[191:0]),
        .sel_rs1(sel_rs1), .sel_rs2(sel_rs2), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_lane_valid(s_out_lane_valid),
        .out_instr(s_out_instr), .out_pc(s_out_pc), .out_op1(s_out_op1), .out_op2(s_out_op2),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand value defined by the select encoding for the 7-bus instance
    function automatic logic [31:0] fwd(input logic [2:0] s, input logic [31:0] rf);
        if (s == 3'd0) return rf;
        return bus[s - 3'd1];
    endfunction

    task automatic offer(input logic [31:0] pc0, input logic [1:0] lv,
                         input logic [2:0] a0, input logic [2:0] b0,
                         input logic [2:0] a1, input logic [2:0] b1, input bit push);
        exp_t e;
        in_valid      = 1'b1;
        in_lane_valid = lv;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc;
            pc = pc0 + 32'(4 * i);
            in_pc[32*i +: 32]       = pc;
            in_instr[32*i +: 32]    = pc ^ 32'h1300_0013;
            rf_rs1_data[32*i +: 32] = pc + 32'd1;
            rf_rs2_data[32*i +: 32] = pc + 32'd2;
        end
        sel_rs1 = {a1, a0};
        sel_rs2 = {b1, b0};
        e.lv    = lv;
        e.pc    = in_pc;
        e.instr = in_instr;
        e.op1   = {fwd(a1, pc0 + 32'd5), fwd(a0, pc0 + 32'd1)};
        e.op2   = {fwd(b1, pc0 + 32'd6), fwd(b0, pc0 + 32'd2)};
        if (push) sb.push_back(e);
    endtask

    // Packet leaves on the next edge whenever valid and ready are both high mid-cycle
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pkt_lane_valid", 64'(out_lane_valid), 64'(mon_e.lv));
                chk("pkt_instr", out_instr, mon_e.instr);
                chk("pkt_pc", out_pc, mon_e.pc);
                chk("pkt_op1", out_op1, mon_e.op1);
                chk("pkt_op2", out_op2, mon_e.op2);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_lane_valid = 2'b00; in_instr = '0; in_pc = '0;
        rf_rs1_data = '0; rf_rs2_data = '0; sel_rs1 = '0; sel_rs2 = '0;
        flush = 1'b0; out_ready = 1'b0;
        bus = '{32'hB0, 32'hB1, 32'd7, 32'hB3, 32'd9, 32'hB5, 32'd11};
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        chk("rst_instr", out_instr, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_op1", out_op1, 64'd0);
        chk("rst_op2", out_op2, 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #10 rst_n = 1'b1;
        tick();

        // Forwarding from register file and bypass buses
        out_ready = 1'b1;
        offer(32'h2, 2'b11, 3'd0, 3'd3, 3'd5, 3'd7, 1'b1);
        tick();
        chk("fwd_op1", out_op1, {32'd9, 32'd3});
        chk("fwd_op2", out_op2, {32'd11, 32'd7});
        chk("fwd_out_valid", 64'(out_valid), 64'd1);
        chk("oor_small_lane1_op2", 64'(s_out_op2[63:32]), 64'd0);

        // Out-of-range select on the 6-bus instance, lane 1 marked invalid
        offer(32'h20, 2'b01, 3'd0, 3'd7, 3'd1, 3'd2, 1'b1);
        tick();
        chk("oor_op1_rf", 64'(s_out_op1[31:0]), 64'h21);
        chk("oor_op2_zero", 64'(s_out_op2[31:0]), 64'd0);
        chk("inrange_op2_bus6", 64'(out_op2[31:0]), 64'd11);
        chk("lane_valid_01", 64'(out_lane_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Backpressure: PC 0x4 then 0x8 while output is stalled
        offer(32'h4, 2'b11, 3'd1, 3'd3, 3'd0, 3'd5, 1'b1);
        tick();
        out_ready = 1'b0;
        bus[0] = 32'hC0; bus[2] = 32'hC2; bus[4] = 32'hC4;
        offer(32'h8, 2'b11, 3'd1, 3'd3, 3'd0, 3'd5, 1'b1);
`ifdef ID_OPERAND_SKID_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        #1;
        chk("bp_in_ready_first", 64'(in_ready), 64'(exp_rdy));
        tick();
`ifdef ID_OPERAND_SKID_EN
        in_valid = 1'b0;
`endif
        tick(); tick(); tick();
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd4);
        chk("bp_small_stall_cnt", 64'(s_stall_cnt), 64'd4);
        chk("bp_in_ready_held", 64'(in_ready), 64'd0);
        chk("bp_held_pc", 64'(out_pc[31:0]), 64'h4);
        chk("bp_held_op1", 64'(out_op1[31:0]), 64'hB0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_second_pc", 64'(out_pc[31:0]), 64'h8);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp_done_valid", 64'(out_valid), 64'd0);
        chk("bp_done_in_ready", 64'(in_ready), 64'd1);

        // Flush with a packet held (and skid full when present)
        out_ready = 1'b0;
        offer(32'hC, 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        tick();
        offer(32'h18, 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        tick();
        chk("fl_pre_stall_cnt", 64'(stall_cnt), 64'd5);
        chk("fl_pre_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        offer(32'h10, 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_stall_cnt_kept", 64'(stall_cnt), 64'd6);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_no_replay", 64'(out_valid), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Saturation: 20 stalled cycles
        out_ready = 1'b0;
        offer(32'h40, 2'b10, 3'd2, 3'd4, 3'd6, 3'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_stall_cnt", 64'(stall_cnt), 64'd26);
        chk("sat_small_stall_cnt", 64'(s_stall_cnt), 64'd15);
        chk("sat_held_pc", 64'(out_pc[31:0]), 64'h40);

        // Asynchronous reset while stalled discards held packets
        offer(32'h44, 2'b11, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        tick();
        chk("sb_pending", 64'(sb.size()), 64'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_pc", out_pc, 64'd0);
        chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("arst_small_stall_cnt", 64'(s_stall_cnt), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
